user_input_irq_ctrl: RTL

Parametrised interrupt controller for board push-buttons and slide switches. It lives inside the FPGA fabric as an Avalon-MM slave in the HPS-attached system. It synchronises and debounces `NUM_INPUTS` raw inputs and detects rising and/or falling edges per channel. It latches those edges into a write-1-to-clear capture register and drives a level IRQ to the HPS GIC whenever any unmasked captured edge is pending.

---
 rtl/user_input_irq_ctrl_if.sv | 35 +++
 rtl/user_input_irq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/user_input_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for user_input_irq_ctrl.
//
// Signals:
//   avs_address   - word address of the register (3 bits)
//   avs_read      - read strobe
//   avs_write     - write strobe
//   avs_writedata - write data (32 bits)
//   avs_readdata  - read data, registered, valid the cycle after avs_read
//
// Modports:
//   master - drives the request, samples readdata (host / testbench side)
//   slave  - samples the request, drives readdata (controller side)
interface user_input_irq_ctrl_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/user_input_irq_ctrl.sv
// Interrupt controller for board push-buttons and slide switches.
//
// Each raw input passes through a SYNC_STAGES flip-flop synchroniser and a
// counter-based debouncer. Accepted level changes are edge-qualified by RISE_EN /
// FALL_EN and latched into a write-1-to-clear capture register. The level irq is
// the registered OR of captured edges that are unmasked.
//
// Register map (word address, bits above NUM_INPUTS read 0):
//   0 DATA         RO    debounced state
//   1 IRQ_MASK     RW    1 = channel may raise irq
//   2 EDGE_CAPTURE R/W1C latched edges
//   3 RISE_EN      RW    capture 0->1 transitions
//   4 FALL_EN      RW    capture 1->0 transitions
//   5 PENDING      RO    EDGE_CAPTURE & IRQ_MASK
//   6..7                 read 0, writes ignored
//
// Ports:
//   clk         - system clock
//   reset       - asynchronous, active-high reset
//   user_inputs - raw asynchronous key/switch levels
//   avs         - Avalon-MM slave (address/read/write/writedata/readdata)
//   irq         - level interrupt, registered
module user_input_irq_ctrl #(
    parameter int unsigned           NUM_INPUTS      = 9,
    parameter int unsigned           DEBOUNCE_CYCLES = 500000,
    parameter int unsigned           SYNC_STAGES     = 2,
    parameter logic [NUM_INPUTS-1:0] RESET_LEVEL     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_INPUTS-1:0]   user_inputs,
    user_input_irq_ctrl_if.slave    avs,
    output logic                    irq
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_CAPTURE = 3'd2;
    localparam logic [2:0] ADDR_RISE    = 3'd3;
    localparam logic [2:0] ADDR_FALL    = 3'd4;
    localparam logic [2:0] ADDR_PENDING = 3'd5;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INPUTS-1:0] sync_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= user_inputs;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      cnt_q [NUM_INPUTS];
    logic [CNT_W-1:0]      cnt_d [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] data_q;
    logic [NUM_INPUTS-1:0] data_d;
    logic [NUM_INPUTS-1:0] settle;

    // The counter only runs while the synchronised level disagrees with the
    // debounced state; reaching CNT_LAST while still disagreeing accepts the new
    // level, so the counter never goes past CNT_LAST and cannot wrap.
    always_comb begin
        data_d = data_q;
        settle = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = '0;
            if (sync_in[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    data_d[i] = sync_in[i];
                    settle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_LEVEL;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers and edge capture
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] irq_mask_q, irq_mask_d;
    logic [NUM_INPUTS-1:0] capture_q, capture_d;
    logic [NUM_INPUTS-1:0] rise_en_q, rise_en_d;
    logic [NUM_INPUTS-1:0] fall_en_q, fall_en_d;
    logic [NUM_INPUTS-1:0] capture_set;
    logic [NUM_INPUTS-1:0] wdata;
    logic                  unused_wdata;

    assign wdata        = avs.avs_writedata[NUM_INPUTS-1:0];
    assign unused_wdata = ^avs.avs_writedata;

    // On a settle cycle the synchronised level is the new level, so a 1 there
    // marks a rising edge and a 0 a falling edge.
    assign capture_set = settle & ((sync_in & rise_en_q) | (~sync_in & fall_en_q));

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        capture_d  = capture_q;
        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_MASK:    irq_mask_d = wdata;
                ADDR_CAPTURE: capture_d  = capture_q & ~wdata;
                ADDR_RISE:    rise_en_d  = wdata;
                ADDR_FALL:    fall_en_d  = wdata;
                default:      ;
            endcase
        end
        // A new edge on the same cycle as its W1C keeps the bit set.
        capture_d = capture_d | capture_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q <= '0;
            capture_q  <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            capture_q  <= capture_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path and interrupt
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic [31:0] readdata_q;
    logic        irq_q;

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:    rd_mux = 32'(data_q);
            ADDR_MASK:    rd_mux = 32'(irq_mask_q);
            ADDR_CAPTURE: rd_mux = 32'(capture_q);
            ADDR_RISE:    rd_mux = 32'(rise_en_q);
            ADDR_FALL:    rd_mux = 32'(fall_en_q);
            ADDR_PENDING: rd_mux = 32'(capture_q & irq_mask_q);
            default:      rd_mux = '0;
        endcase
    end

    // Reads sample current register values, so a same-cycle write to the same
    // address is not yet visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (avs.avs_read) begin
                readdata_q <= rd_mux;
            end
            irq_q <= |(capture_q & irq_mask_q);
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;

endmodule
